vdec_hs_scch_sel: RTL and testbench

HS-SCCH part-1 candidate sequencer and selector in the HS control-channel decode path. For each configured HS-SCCH candidate code, up to four, it launches the Viterbi decoder and then the symbol-error calculator on that candidate's soft symbols. It collects each candidate's symbol-error count and selects the best candidate that falls under a programmable threshold. It drives the SER stage's `start`, `base_sys` and `dec_bits` inputs and consumes its `done` and `ser_acc` outputs.

---
 rtl/vdec_hs_scch_sel.sv | 149 ++++++++++++++
 tb/tb_vdec_hs_scch_sel.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdec_hs_scch_sel.sv
// HS-SCCH part-1 candidate sequencer: runs Viterbi then SER on up to four
// candidates and keeps the lowest-SER candidate at or under the threshold.
module vdec_hs_scch_sel (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [1:0]  num_cand_m1,
    input  logic [35:0] cand_base,
    input  logic [6:0]  ser_thr,
    output logic        vit_start,
    output logic [8:0]  vit_base,
    input  logic        vit_done,
    input  logic [28:0] vit_bits,
    output logic        ser_start,
    output logic [15:0] ser_base_sys,
    output logic [28:0] ser_dec_bits,
    input  logic        ser_done,
    input  logic [6:0]  ser_acc,
    output logic        det_valid,
    output logic [1:0]  det_idx,
    output logic [6:0]  det_ser,
    output logic [7:0]  det_bits
);

    typedef enum logic [2:0] {
        IDLE, VIT, VWAIT, SER, SWAIT, CMP, DONE
    } state_t;

    state_t      state;
    logic [1:0]  cand;
    logic [1:0]  num_q;
    logic [35:0] base_q;
    logic [6:0]  thr_q;
    logic [6:0]  cur_ser;
    logic [6:0]  best_ser;
    logic [1:0]  best_idx;
    logic [7:0]  best_bits;
    logic        found;

    logic        accept;
    logic [1:0]  cand_nxt;
    logic [8:0]  next_base;

    // The !found term lets a threshold of 127 accept an SER of 127 too;
    // once something is found the strict compare keeps the lowest index on ties.
    always_comb begin
        accept   = (cur_ser <= thr_q) && (!found || (cur_ser < best_ser));
        cand_nxt = cand + 2'd1;
        case (cand_nxt)
            2'd0:    next_base = base_q[8:0];
            2'd1:    next_base = base_q[17:9];
            2'd2:    next_base = base_q[26:18];
            default: next_base = base_q[35:27];
        endcase
    end

    assign busy         = (state != IDLE);
    assign ser_base_sys = {7'd0, vit_base};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cand         <= 2'd0;
            num_q        <= 2'd0;
            base_q       <= 36'd0;
            thr_q        <= 7'd0;
            cur_ser      <= 7'd0;
            best_ser     <= 7'd127;
            best_idx     <= 2'd0;
            best_bits    <= 8'd0;
            found        <= 1'b0;
            done         <= 1'b0;
            vit_start    <= 1'b0;
            vit_base     <= 9'd0;
            ser_start    <= 1'b0;
            ser_dec_bits <= 29'd0;
            det_valid    <= 1'b0;
            det_idx      <= 2'd0;
            det_ser      <= 7'd127;
            det_bits     <= 8'd0;
        end else begin
            vit_start <= 1'b0;
            ser_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q     <= num_cand_m1;
                        base_q    <= cand_base;
                        thr_q     <= ser_thr;
                        cand      <= 2'd0;
                        best_ser  <= 7'd127;
                        best_idx  <= 2'd0;
                        best_bits <= 8'd0;
                        found     <= 1'b0;
                        det_valid <= 1'b0;
                        det_idx   <= 2'd0;
                        det_ser   <= 7'd127;
                        det_bits  <= 8'd0;
                        vit_base  <= cand_base[8:0];
                        vit_start <= 1'b1;
                        state     <= VIT;
                    end
                end
                VIT: state <= VWAIT;
                VWAIT: begin
                    if (vit_done) begin
                        ser_dec_bits <= vit_bits;
                        ser_start    <= 1'b1;
                        state        <= SER;
                    end
                end
                SER: state <= SWAIT;
                SWAIT: begin
                    if (ser_done) begin
                        cur_ser <= ser_acc;
                        state   <= CMP;
                    end
                end
                CMP: begin
                    if (accept) begin
                        best_ser  <= cur_ser;
                        best_idx  <= cand;
                        best_bits <= ser_dec_bits[7:0];
                        found     <= 1'b1;
                    end
                    if (cand == num_q) begin
                        det_valid <= found | accept;
                        det_idx   <= accept ? cand : best_idx;
                        det_ser   <= accept ? cur_ser : best_ser;
                        det_bits  <= accept ? ser_dec_bits[7:0] : best_bits;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cand      <= cand_nxt;
                        vit_base  <= next_base;
                        vit_start <= 1'b1;
                        state     <= VIT;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdec_hs_scch_sel.sv
// Self-checking bench for vdec_hs_scch_sel: plays the Viterbi and SER stages
// and scoreboards the expected selection of each detection run.
module tb_vdec_hs_scch_sel;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  num_cand_m1;
    logic [35:0] cand_base;
    logic [6:0]  ser_thr;
    logic        vit_start;
    logic [8:0]  vit_base;
    logic        vit_done;
    logic [28:0] vit_bits;
    logic        ser_start;
    logic [15:0] ser_base_sys;
    logic [28:0] ser_dec_bits;
    logic        ser_done;
    logic [6:0]  ser_acc;
    logic        det_valid;
    logic [1:0]  det_idx;
    logic [6:0]  det_ser;
    logic [7:0]  det_bits;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
        logic [6:0] ser;
        logic [7:0] bits;
    } exp_t;

    exp_t        sb[$];
    logic [28:0] cfg_bits [4];
    logic [6:0]  cfg_ser [4];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          vit_cnt = 0;
    int          ser_cnt = 0;
    int          done_cnt = 0;

    vdec_hs_scch_sel dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .num_cand_m1(num_cand_m1), .cand_base(cand_base), .ser_thr(ser_thr),
        .vit_start(vit_start), .vit_base(vit_base), .vit_done(vit_done),
        .vit_bits(vit_bits), .ser_start(ser_start), .ser_base_sys(ser_base_sys),
        .ser_dec_bits(ser_dec_bits), .ser_done(ser_done), .ser_acc(ser_acc),
        .det_valid(det_valid), .det_idx(det_idx), .det_ser(det_ser),
        .det_bits(det_bits)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vit_start) vit_cnt++;
        if (ser_start) ser_cnt++;
        if (done)      done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full detection; rst_cand >= 0 asserts reset in that candidate's SWAIT.
    task automatic run_detection(input logic [1:0] n, input logic [35:0] bases,
                                 input logic [6:0] thr, input int vdly, input int sdly,
                                 input bit spurious, input int rst_cand);
        exp_t e;
        exp_t got;
        e = '{valid: 1'b0, idx: 2'd0, ser: 7'd127, bits: 8'd0};
        for (int i = 0; i <= int'(n); i++) begin
            if (cfg_ser[i] <= thr && (!e.valid || cfg_ser[i] < e.ser))
                e = '{valid: 1'b1, idx: 2'(i), ser: cfg_ser[i], bits: cfg_bits[i][7:0]};
        end
        sb.push_back(e);
        vit_cnt = 0;
        ser_cnt = 0;
        done_cnt = 0;
        num_cand_m1 = n;
        cand_base = bases;
        ser_thr = thr;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_cand_m1 = 2'($urandom);
        ser_thr = 7'($urandom);
        tests_run++;
        if ({busy, det_valid, det_ser, det_bits} !== {1'b1, 1'b0, 7'd127, 8'd0}) begin
            tests_failed++;
            $display("[TB] FAIL start_clear: busy/valid/ser/bits got %b/%b/%0d/%h expected 1/0/127/00",
                     busy, det_valid, det_ser, det_bits);
        end
        for (int c = 0; c <= int'(n); c++) begin
            tests_run++;
            if (vit_start !== 1'b1 || vit_base !== bases[9*c +: 9] ||
                ser_base_sys !== {7'd0, bases[9*c +: 9]}) begin
                tests_failed++;
                $display("[TB] FAIL vit_launch c%0d: vit_start=%b vit_base=%h sys=%h expected 1 %h %h",
                         c, vit_start, vit_base, ser_base_sys, bases[9*c +: 9], {7'd0, bases[9*c +: 9]});
            end
            tick();
            if (spurious && c == 0) begin
                start = 1'b1;
                ser_done = 1'b1;
                ser_acc = 7'd0;
                tick();
                start = 1'b0;
                ser_done = 1'b0;
            end
            repeat (vdly) tick();
            vit_done = 1'b1;
            vit_bits = cfg_bits[c];
            tick();
            vit_done = 1'b0;
            vit_bits = 29'($urandom);
            tests_run++;
            if (ser_start !== 1'b1 || ser_dec_bits !== cfg_bits[c]) begin
                tests_failed++;
                $display("[TB] FAIL ser_launch c%0d: ser_start=%b dec_bits=%h expected 1 %h",
                         c, ser_start, ser_dec_bits, cfg_bits[c]);
            end
            tick();
            repeat (sdly) tick();
            if (c == rst_cand) begin
                #2 rst = 1'b1;
                #1;
                tests_run++;
                if ({busy, done, vit_start, ser_start, vit_base, ser_base_sys, ser_dec_bits,
                     det_valid, det_idx, det_ser, det_bits} !==
                    {1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0, 29'd0, 1'b0, 2'd0, 7'd127, 8'd0}) begin
                    tests_failed++;
                    $display("[TB] FAIL async_reset: busy=%b done=%b vb=%h dec=%h valid=%b ser=%0d expected all 0, det_ser 127",
                             busy, done, vit_base, ser_dec_bits, det_valid, det_ser);
                end
                tick();
                rst = 1'b0;
                repeat (10) tick();
                tests_run++;
                if (done_cnt !== 0 || busy !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL reset_no_done: done pulses=%0d busy=%b expected 0 0", done_cnt, busy);
                end
                void'(sb.pop_front());
                return;
            end
            ser_done = 1'b1;
            ser_acc = cfg_ser[c];
            tick();
            ser_done = 1'b0;
            ser_acc = 7'($urandom);
            tests_run++;
            if (done !== 1'b0 || vit_start !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL cmp_cycle c%0d: done=%b vit_start=%b expected 0 0", c, done, vit_start);
            end
            tick();
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL done_latency: done=%b expected 1 two cycles after ser_done", done);
        end
        got = '{valid: det_valid, idx: det_idx, ser: det_ser, bits: det_bits};
        e = sb.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("[TB] FAIL det_result: valid/idx/ser/bits got %b/%0d/%0d/%h expected %b/%0d/%0d/%h",
                     got.valid, got.idx, got.ser, got.bits, e.valid, e.idx, e.ser, e.bits);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || got !== {det_valid, det_idx, det_ser, det_bits}) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_done: done=%b busy=%b det held=%b expected 0 0 1",
                     done, busy, got === {det_valid, det_idx, det_ser, det_bits});
        end
        tests_run++;
        if (vit_cnt !== int'(n) + 1 || ser_cnt !== int'(n) + 1 || done_cnt !== 1) begin
            tests_failed++;
            $display("[TB] FAIL pulse_counts: vit=%0d ser=%0d done=%0d expected %0d %0d 1",
                     vit_cnt, ser_cnt, done_cnt, int'(n) + 1, int'(n) + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        num_cand_m1 = 2'd0;
        cand_base = 36'd0;
        ser_thr = 7'd0;
        vit_done = 1'b0;
        vit_bits = 29'd0;
        ser_done = 1'b0;
        ser_acc = 7'd0;
        repeat (3) tick();
        tests_run++;
        if ({busy, done, vit_start, ser_start, vit_base, ser_base_sys, ser_dec_bits,
             det_valid, det_idx, det_ser, det_bits} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0, 29'd0, 1'b0, 2'd0, 7'd127, 8'd0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: busy=%b done=%b valid=%b det_ser=%0d expected 0 0 0 127",
                     busy, done, det_valid, det_ser);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        cfg_bits[0] = {21'h1B_2C3D, 8'hA5};
        cfg_ser[0] = 7'd3;
        run_detection(2'd0, {27'h7FF_FFFF, 9'h040}, 7'd10, 0, 0, 1'b0, -1);
    endtask

    task automatic test_four_best();
        cfg_bits[0] = 29'h0AB_CD11;
        cfg_bits[1] = 29'h123_4522;
        cfg_bits[2] = 29'h0F0_0F33;
        cfg_bits[3] = 29'h1FF_FF44;
        cfg_ser = '{7'd9, 7'd4, 7'd4, 7'd12};
        run_detection(2'd3, {9'h1C3, 9'h0B2, 9'h0A1, 9'h010}, 7'd8, 1, 2, 1'b0, -1);
    endtask

    task automatic test_none();
        cfg_bits[0] = 29'h111_1177;
        cfg_bits[1] = 29'h022_2288;
        cfg_ser[0] = 7'd20;
        cfg_ser[1] = 7'd30;
        run_detection(2'd1, {18'd0, 9'h155, 9'h0AA}, 7'd15, 3, 0, 1'b0, -1);
    endtask

    task automatic test_threshold();
        cfg_bits[0] = 29'h000_0A5C;
        cfg_ser[0] = 7'd5;
        run_detection(2'd0, 36'h0000_0012, 7'd5, 0, 1, 1'b0, -1);
        cfg_ser[0] = 7'd6;
        run_detection(2'd0, 36'h0000_0012, 7'd5, 0, 1, 1'b0, -1);
        cfg_bits[0] = 29'h000_00E1;
        cfg_bits[1] = 29'h000_00E2;
        cfg_ser[0] = 7'd1;
        cfg_ser[1] = 7'd0;
        run_detection(2'd1, {18'd0, 9'h0F1, 9'h0F0}, 7'd0, 0, 0, 1'b0, -1);
    endtask

    task automatic test_spurious();
        cfg_bits[0] = 29'h0C0_FF5A;
        cfg_bits[1] = 29'h0C0_FF6B;
        cfg_ser[0] = 7'd7;
        cfg_ser[1] = 7'd2;
        run_detection(2'd1, {18'd0, 9'h1EE, 9'h0DD}, 7'd9, 0, 0, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        cfg_bits[0] = 29'h1AB_CDEF;
        cfg_ser[0] = 7'd1;
        run_detection(2'd0, 36'h0000_0033, 7'd4, 0, 0, 1'b0, -1);
        cfg_ser[0] = 7'd50;
        run_detection(2'd0, 36'h0000_0044, 7'd4, 0, 0, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        cfg_bits = '{29'h000_0001, 29'h000_0002, 29'h000_0003, 29'h000_0004};
        cfg_ser = '{7'd10, 7'd11, 7'd1, 7'd2};
        run_detection(2'd3, {9'h104, 9'h103, 9'h102, 9'h101}, 7'd20, 0, 1, 1'b0, 2);
        cfg_ser = '{7'd10, 7'd11, 7'd1, 7'd2};
        run_detection(2'd3, {9'h104, 9'h103, 9'h102, 9'h101}, 7'd20, 0, 0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_four_best();
        test_none();
        test_threshold();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
